// File: rtl/cart_resp_pkg.sv
// cart_resp_pkg: shared FSM states, bus address map constants and decode helper for cart_responder.
package cart_resp_pkg;
  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, RD_HOLD, WR_DEC, WR_MEM} state_t;
  localparam logic [15:0] ROM0_END = 16'h3FFF;
  localparam logic [15:0] ROMX_END = 16'h7FFF;
  localparam logic [15:0] RAM_BASE = 16'hA000;
  localparam logic [15:0] RAM_END = 16'hBFFF;
  localparam logic [3:0] RAM_EN_KEY = 4'hA;
  localparam logic [7:0] UNMAPPED_RD = 8'hFF;
  function automatic logic is_ram(input logic [15:0] a, input logic ncs);
    return a >= RAM_BASE && a <= RAM_END && !ncs;
  endfunction
endpackage

// File: rtl/cart_bus_sync.sv
// cart_bus_sync: N-stage synchronizer for the 27 cartridge bus bits, with the previous synchronized
// sample kept for write capture and nrd fall / nwr rise pulses.
module cart_bus_sync #(
  parameter int N = 2
) (
  input  logic        clk_8m,
  input  logic        rst_n,
  input  logic [15:0] a,
  input  logic [7:0]  d,
  input  logic        nrd,
  input  logic        nwr,
  input  logic        ncs,
  output logic [15:0] a_s,
  output logic [15:0] a_p,
  output logic [7:0]  d_p,
  output logic        nrd_s,
  output logic        nwr_s,
  output logic        ncs_s,
  output logic        ncs_p,
  output logic        nrd_fall,
  output logic        nwr_rise
);
  localparam logic [26:0] IDLE_BUS = {24'h0, 3'b111};
  logic [26:0] sr [N];
  logic [26:0] cur, prev;
  always_ff @(posedge clk_8m or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < N; i++) sr[i] <= IDLE_BUS;
      prev <= IDLE_BUS;
    end else begin
      sr[0] <= {a, d, nrd, nwr, ncs};
      for (int i = 1; i < N; i++) sr[i] <= sr[i-1];
      prev <= cur;
    end
  assign cur = sr[N-1];
  assign a_s = cur[26:11];
  assign nrd_s = cur[2];
  assign nwr_s = cur[1];
  assign ncs_s = cur[0];
  assign a_p = prev[26:11];
  assign d_p = prev[10:3];
  assign ncs_p = prev[0];
  assign nrd_fall = prev[2] & ~cur[2];
  assign nwr_rise = ~prev[1] & cur[1];
endmodule

// File: rtl/cart_responder.sv
// cart_responder: cartridge-bus target serving reads/writes from a backing memory port.
// Define CART_RESP_MBC1_EN to compile in MBC1 bank / RAM-enable registers.
module cart_responder
  import cart_resp_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MEM_AW = 21
) (
  input  logic              clk_8m,
  input  logic              rst_n,
  input  logic [15:0]       cart_a,
  input  logic [7:0]        cart_d_in,
  input  logic              cart_nrd,
  input  logic              cart_nwr,
  input  logic              cart_ncs,
  output logic [7:0]        cart_d_out,
  output logic              cart_d_oe,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_ram,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack,
  output logic [6:0]        rom_bank,
  output logic              rd_late,
  output logic              bus_err
);
  logic [15:0] a_s, a_p;
  logic [7:0] d_p;
  logic nrd_s, nwr_s, ncs_s, ncs_p, nrd_fall, nwr_rise;
  logic ram_en, late, wr_go, rd_map, err;
  state_t state, nxt;
  cart_bus_sync #(.N(SYNC_STAGES)) u_sync (
    .clk_8m(clk_8m), .rst_n(rst_n), .a(cart_a), .d(cart_d_in), .nrd(cart_nrd), .nwr(cart_nwr),
    .ncs(cart_ncs), .a_s(a_s), .a_p(a_p), .d_p(d_p), .nrd_s(nrd_s), .nwr_s(nwr_s), .ncs_s(ncs_s),
    .ncs_p(ncs_p), .nrd_fall(nrd_fall), .nwr_rise(nwr_rise)
  );
  function automatic logic [MEM_AW-1:0] map_addr(input logic [15:0] a, input logic ncs,
                                                 input logic [6:0] bank);
    if (is_ram(a, ncs)) return MEM_AW'(a[12:0]);
    return a <= ROM0_END ? MEM_AW'(a[13:0]) : MEM_AW'({bank, a[13:0]});
  endfunction
  // A write strobe release while nrd is still low belongs to a collided cycle and is dropped.
  assign wr_go = nwr_rise & nrd_s;
  assign rd_map = a_s <= ROMX_END || is_ram(a_s, ncs_s);
  assign err = state == IDLE ? (nrd_fall & ~nwr_s) | (nwr_rise & ~nrd_s) : nrd_fall | nwr_rise;
  always_ff @(posedge clk_8m or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = nrd_fall ? (rd_map ? RD_REQ : RD_HOLD) : wr_go ? WR_DEC : IDLE;
      RD_REQ:  nxt = RD_WAIT;
      RD_WAIT: nxt = mem_ack ? (late | nrd_s ? IDLE : RD_HOLD) : RD_WAIT;
      RD_HOLD: nxt = nrd_s ? IDLE : RD_HOLD;
      WR_DEC:  nxt = mem_wr ? WR_MEM : IDLE;
      WR_MEM:  nxt = mem_ack ? IDLE : WR_MEM;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    mem_rd = state == RD_REQ;
    mem_wr = state == WR_DEC && mem_ram && ram_en;
    cart_d_oe = state == RD_HOLD;
  end
  always_ff @(posedge clk_8m or negedge rst_n)
    if (!rst_n) begin
      mem_addr <= '0;
      mem_ram <= 1'b0;
      mem_wdata <= '0;
      cart_d_out <= '0;
      late <= 1'b0;
      rd_late <= 1'b0;
      bus_err <= 1'b0;
    end else begin
      if (state == IDLE && nrd_fall) begin
        mem_addr <= map_addr(a_s, ncs_s, rom_bank);
        mem_ram <= is_ram(a_s, ncs_s);
        late <= 1'b0;
        if (!rd_map) cart_d_out <= UNMAPPED_RD;
      end else if (state == IDLE && wr_go) begin
        mem_addr <= map_addr(a_p, ncs_p, rom_bank);
        mem_ram <= is_ram(a_p, ncs_p);
        mem_wdata <= d_p;
      end
      if (state == RD_WAIT && mem_ack) cart_d_out <= mem_rdata;
      if ((state == RD_REQ || state == RD_WAIT) && nrd_s) begin
        late <= 1'b1;
        rd_late <= 1'b1;
      end
      if (err) bus_err <= 1'b1;
    end
`ifdef CART_RESP_MBC1_EN
  logic [15:0] w_a;
  logic [6:0] bank;
  logic ram_en_r;
  always_ff @(posedge clk_8m or negedge rst_n)
    if (!rst_n) begin
      w_a <= '0;
      bank <= 7'd1;
      ram_en_r <= 1'b0;
    end else begin
      if (state == IDLE && wr_go && !nrd_fall) w_a <= a_p;
      if (state == WR_DEC && w_a[15:13] == 3'b000) ram_en_r <= mem_wdata[3:0] == RAM_EN_KEY;
      if (state == WR_DEC && w_a[15:13] == 3'b001) bank[4:0] <= mem_wdata[4:0] == 5'd0 ? 5'd1 : mem_wdata[4:0];
      if (state == WR_DEC && w_a[15:13] == 3'b010) bank[6:5] <= mem_wdata[1:0];
    end
  assign rom_bank = bank;
  assign ram_en = ram_en_r;
`else
  assign rom_bank = 7'd1;
  assign ram_en = 1'b1;
`endif
endmodule
